// File: rtl/cnn16_sequencer.sv
// cnn16_sequencer
// Multi-cycle fetch/decode/execute controller for the cnn16 16-bit datapath.
// It decodes the fetched instruction into datapath load/increment/bus/ALU
// controls, flag-capture enables and the memory write strobe.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             leave IDLE, or resume from HALT
//   IR_Value          datapath IR: [15:12] opcode, [11:0] address
//   zero, neg         datapath flags, valid the cycle after their check enable
//   AC_Load, DR_Load, IR_Load, PC_Load, AR_Load, PC_Inc   datapath controls
//   Zero_Check_En, neg_check_en                           flag capture enables
//   bus_sel           datapath bus source (31 = zero / idle)
//   alu_sel           ALU operation
//   mem_we            memory write strobe (data = bus, address = AR)
//   busy, halted      status
//   illegal           sticky illegal-opcode flag
//   instr_count       retired-instruction counter (wraps)
//
// Configuration macro: CNN16_SEQ_ILLEGAL_TRAP_EN
//   defined   : opcodes 7..E halt the sequencer and set the sticky illegal flag
//   undefined : opcodes 7..E execute as NOP and illegal is tied low

module cnn16_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] IR_Value,
    input  logic        zero,
    input  logic        neg,
    output logic        AC_Load,
    output logic        DR_Load,
    output logic        IR_Load,
    output logic        PC_Load,
    output logic        AR_Load,
    output logic        PC_Inc,
    output logic        Zero_Check_En,
    output logic        neg_check_en,
    output logic [4:0]  bus_sel,
    output logic [3:0]  alu_sel,
    output logic        mem_we,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_PASSB = 4'd1;

    localparam logic [4:0] BUS_AC   = 5'd1;
    localparam logic [4:0] BUS_PC   = 5'd3;
    localparam logic [4:0] BUS_MEM  = 5'd4;
    localparam logic [4:0] BUS_IR   = 5'd14;
    localparam logic [4:0] BUS_NONE = 5'd31;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_JN  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_DECODE,
        S_EXEC0,
        S_EXEC1,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    logic        retire;
    logic        is_illegal_op;

    // Only the opcode field is decoded here; the address bits go to the datapath.
    logic unused_addr_bits;
    assign unused_addr_bits = ^IR_Value[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= OP_NOP;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    assign is_illegal_op = (IR_Value[15:12] > OP_JN) && (IR_Value[15:12] != OP_HLT);

    // Controls are a pure decode of the current state and latched opcode, so an
    // asynchronous reset drops every strobe in the same cycle.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        illegal_d     = illegal_q;
        retire        = 1'b0;
        AC_Load       = 1'b0;
        DR_Load       = 1'b0;
        IR_Load       = 1'b0;
        PC_Load       = 1'b0;
        AR_Load       = 1'b0;
        PC_Inc        = 1'b0;
        Zero_Check_En = 1'b0;
        neg_check_en  = 1'b0;
        mem_we        = 1'b0;
        bus_sel       = BUS_NONE;
        alu_sel       = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH0;
            end
            S_FETCH0: begin
                bus_sel = BUS_PC;
                AR_Load = 1'b1;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                bus_sel = BUS_MEM;
                IR_Load = 1'b1;
                PC_Inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                bus_sel  = BUS_IR;
                AR_Load  = 1'b1;
                opcode_d = IR_Value[15:12];
                if (IR_Value[15:12] == OP_NOP) begin
                    retire  = 1'b1;
                    state_d = S_FETCH0;
                end else if (IR_Value[15:12] == OP_HLT) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (is_illegal_op) begin
                    retire = 1'b1;
`ifdef CNN16_SEQ_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    state_d   = S_FETCH0;
`endif
                end else begin
                    state_d = S_EXEC0;
                end
            end
            S_EXEC0: begin
                state_d = S_FETCH0;
                case (opcode_q)
                    OP_LDA, OP_ADD: begin
                        bus_sel = BUS_MEM;
                        DR_Load = 1'b1;
                        state_d = S_EXEC1;
                    end
                    OP_STA: begin
                        bus_sel = BUS_AC;
                        mem_we  = 1'b1;
                        retire  = 1'b1;
                    end
                    OP_JMP: begin
                        bus_sel = BUS_IR;
                        PC_Load = 1'b1;
                        retire  = 1'b1;
                    end
                    // The AC is put on the bus so the datapath flags see it.
                    OP_JZ: begin
                        bus_sel       = BUS_AC;
                        Zero_Check_En = 1'b1;
                        state_d       = S_EXEC1;
                    end
                    OP_JN: begin
                        bus_sel      = BUS_AC;
                        neg_check_en = 1'b1;
                        state_d      = S_EXEC1;
                    end
                    default: ;
                endcase
            end
            S_EXEC1: begin
                retire  = 1'b1;
                state_d = S_FETCH0;
                case (opcode_q)
                    OP_LDA: begin
                        alu_sel = ALU_PASSB;
                        AC_Load = 1'b1;
                    end
                    OP_ADD: begin
                        alu_sel = ALU_ADD;
                        AC_Load = 1'b1;
                    end
                    OP_JZ: begin
                        if (zero) begin
                            bus_sel = BUS_IR;
                            PC_Load = 1'b1;
                        end
                    end
                    OP_JN: begin
                        if (neg) begin
                            bus_sel = BUS_IR;
                            PC_Load = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                if (start) state_d = S_FETCH0;
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q + {15'd0, retire};
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

`ifdef CNN16_SEQ_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/cnn16_sequencer.md
# cnn16_sequencer

Multi-cycle fetch/decode/execute controller for the cnn16 16-bit datapath. It drives the datapath's load, increment, bus-select, ALU-select and flag-capture controls from the fetched instruction word. It also generates the memory write strobe. It sits beside the datapath and samples `IR_Value` and the `zero`/`neg` flags.

## Interface
- `ALU_PASSB`, 4'd1, `alu_sel` code where the ALU result equals the DR operand.
- `ALU_ADD`, 4'd0, `alu_sel` code where the ALU result is AC + DR.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin execution from IDLE, or resume from HALT.
- `IR_Value`  in  16  datapath IR; [15:12] opcode, [11:0] address.
- `zero`, `neg`  in  1  datapath flags, valid the cycle after their check enable.
- `AC_Load`, `DR_Load`, `IR_Load`, `PC_Load`, `AR_Load`, `PC_Inc`  out  1  datapath controls.
- `Zero_Check_En`, `neg_check_en`  out  1  flag capture enables.
- `bus_sel`  out  5  datapath bus source.
- `alu_sel`  out  4  ALU operation.
- `mem_we`  out  1  memory write strobe; data is `to_memory`, address is AR.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky illegal-opcode flag (see Configuration).
- `instr_count`  out  16  retired-instruction counter.

## Operation
- Memory read is asynchronous: `from_memory` is valid in the same cycle AR is stable.
- Bus codes used:
  - 0 = DR, 1 = AC, 3 = PC, 4 = MEM, 14 = IR.
  - 31 = zero; this is the idle value of `bus_sel`.
- States: IDLE, FETCH0, FETCH1, DECODE, EXEC0, EXEC1, HALT.
- Outputs are a Moore decode of state plus latched IR opcode. Any control not listed for a state is 0.
- IDLE: `start` → FETCH0.
- FETCH0: `bus_sel=3`, `AR_Load`.
- FETCH1: `bus_sel=4`, `IR_Load`, `PC_Inc`.
- DECODE: `bus_sel=14`, `AR_Load`. Next state by opcode:
  - 0 NOP → FETCH0.
  - 1 LDA, 2 STA, 3 ADD, 4 JMP, 5 JZ, 6 JN → EXEC0.
  - F HLT → HALT.
  - 7–E illegal → see Configuration.
- EXEC0:
  - LDA/ADD: `bus_sel=4`, `DR_Load` → EXEC1.
  - STA: `bus_sel=1`, `mem_we` → FETCH0.
  - JMP: `bus_sel=14`, `PC_Load` → FETCH0.
  - JZ: `bus_sel=1`, `Zero_Check_En` → EXEC1.
  - JN: `bus_sel=1`, `neg_check_en` → EXEC1.
- EXEC1:
  - LDA: `alu_sel=ALU_PASSB`, `AC_Load`.
  - ADD: `alu_sel=ALU_ADD`, `AC_Load`.
  - JZ: if `zero`, `bus_sel=14`, `PC_Load`.
  - JN: if `neg`, `bus_sel=14`, `PC_Load`.
  - Next state is always FETCH0.
- HALT: `start` → FETCH0, resuming at the current PC. Otherwise stay in HALT.
- `instr_count` increments by one on the final cycle of every instruction, HLT included. It wraps 16'hFFFF → 0.
- `start` is ignored outside IDLE and HALT.

## Timing
- Reset values: state IDLE, `bus_sel=5'd31`, `alu_sel=0`, `instr_count=0`, `illegal=0`, every 1-bit output 0.
- Asynchronous `rst` mid-instruction forces IDLE immediately. All strobes drop in the same cycle, so no partial `mem_we` or `PC_Load` occurs after the reset assertion.
- Instruction latency, counted from FETCH0 entry to the next FETCH0 entry:
  - NOP 3 cycles.
  - STA, JMP 4 cycles.
  - LDA, ADD, JZ, JN 5 cycles.
- From IDLE, FETCH0 is entered on the cycle after `start` is sampled high.
- JZ/JN test the AC value present in EXEC0. The flag is captured at the end of EXEC0 and used combinationally in EXEC1.
- `PC_Load` and `PC_Inc` are never asserted together.
- The PC wraps 12'hFFF → 0; the wrap is handled by the datapath.

## Configuration
- `CNN16_SEQ_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT. It also sets `illegal` (sticky, cleared only by `rst`) and retires the instruction (`instr_count` increments).
- Macro undefined: illegal opcodes execute as NOP (3 cycles), and `illegal` is tied 0.

## Test plan
- Reset, then `start`, with mem[0]=16'h1010 (LDA 0x010), mem[0x010]=16'h0007, mem[1]=16'hF000 → AC=7, `halted`=1 after 8 cycles, `instr_count`=2.
- Program LDA 0x010 (=5); ADD 0x011 (=3); STA 0x012; HLT → one `mem_we` pulse with AR=0x012 and bus=8; `instr_count`=4.
- JZ 0x020 taken and not taken:
  - AC=0 → PC=0x020 at next FETCH0.
  - AC=1 → PC=0x001 (sequential).
  - JN with AC=16'h8000 → taken.
- Assert `rst` during EXEC0 of STA → `mem_we` low the same cycle; state IDLE; outputs at reset values; `instr_count`=0.
- Opcode 16'h9000 at mem[0]:
  - Macro defined → HALT with `illegal`=1.
  - Macro undefined → 3-cycle NOP, then the next fetch from PC=1.
- In HALT, pulse `start` → FETCH0 at the PC following HLT. Preload `instr_count`=16'hFFFF → wraps to 0 on the next retire.
